// File: rtl/rev_addn_seq_if.sv
// Operand / result / backward-port bundle for rev_addn_seq.
// Every dual-rail field is carried as a true rail and a complement rail.
interface rev_addn_seq_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] a_n;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] b_n;
  logic             cin;
  logic             cin_n;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_n;
  logic             cout;
  logic             cout_n;
  logic [WIDTH-1:0] a_b;
  logic [WIDTH-1:0] a_b_n;
  logic             bck_valid;
  logic             err_dr;
  logic             err_rev;

  // Operand staging side: drives operands and accepts results.
  modport master (
    output in_valid, a, a_n, b, b_n, cin, cin_n, out_ready,
    input  in_ready, out_valid, s, s_n, cout, cout_n,
           a_b, a_b_n, bck_valid, err_dr, err_rev
  );

  // Adder side.
  modport slave (
    input  in_valid, a, a_n, b, b_n, cin, cin_n, out_ready,
    output in_ready, out_valid, s, s_n, cout, cout_n,
           a_b, a_b_n, bck_valid, err_dr, err_rev
  );
endinterface

// File: rtl/rev_addn_seq.sv
// Sequenced dual-rail reversible adder.
// Adds A + B + cin one SLICE-bit slice per cycle (LSB slice first), holds the
// sum for the consumer, then uncomputes MSB slice first, recovering A as
// s ^ b ^ c and clearing the stored sum/carry bits as it goes. The recovered
// A is presented on the backward port and compared with the latched A.
module rev_addn_seq #(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  rev_addn_seq_if.slave bus
);

  localparam int K  = WIDTH / SLICE;
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [CW-1:0] LAST = CW'(K - 1);

  generate
    if (SLICE < 1 || WIDTH < SLICE || (WIDTH % SLICE) != 0) begin : g_bad_param
      $error("rev_addn_seq: WIDTH must be a positive multiple of SLICE");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    FWD  = 3'd1,
    HOLD = 3'd2,
    BWD  = 3'd3,
    DONE = 3'd4
  } state_t;

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH:0]   c_q, c_d;
  logic [WIDTH-1:0] a_rec_q, a_rec_d;
  logic             out_valid_q, out_valid_d;
  logic             bck_valid_q, bck_valid_d;
  logic             err_dr_q, err_dr_d;
  logic             err_rev_q, err_rev_d;
  logic             in_ok;

  // A rail vector is legal when every pair is exactly one-hot.
  function automatic logic rails_legal(input logic [WIDTH-1:0] t,
                                       input logic [WIDTH-1:0] f);
    return &(t ^ f);
  endfunction

  // Full-adder carry.
  function automatic logic maj(input logic x, input logic y, input logic z);
    return (x & y) | (z & (x ^ y));
  endfunction

  assign in_ok = rails_legal(bus.a, bus.a_n) & rails_legal(bus.b, bus.b_n) &
                 (bus.cin ^ bus.cin_n);

  // Next-state and datapath: one slice per cycle in FWD and BWD.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    c_d         = c_q;
    a_rec_d     = a_rec_q;
    out_valid_d = 1'b0;
    bck_valid_d = 1'b0;
    err_dr_d    = 1'b0;
    err_rev_d   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          if (in_ok) begin
            a_d     = bus.a;
            b_d     = bus.b;
            c_d     = {{WIDTH{1'b0}}, bus.cin};
            sum_d   = '0;
            cnt_d   = '0;
            state_d = FWD;
          end else begin
            err_dr_d = 1'b1;
          end
        end
      end

      FWD: begin
        // Carry ripples through the active slice from c[i*SLICE].
        for (int k = 0; k < WIDTH; k++) begin
          if ((k / SLICE) == int'(cnt_q)) begin
            sum_d[k]  = a_q[k] ^ b_q[k] ^ c_d[k];
            c_d[k+1]  = maj(a_q[k], b_q[k], c_d[k]);
          end
        end
        if (cnt_q == LAST) begin
          state_d     = HOLD;
          out_valid_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

      HOLD: begin
        if (bus.out_ready) begin
          state_d = BWD;
          cnt_d   = LAST;
        end else begin
          out_valid_d = 1'b1;
        end
      end

      BWD: begin
        // Lower-slice carry c[j*SLICE] is still intact because slices
        // are uncomputed from the top down.
        for (int k = 0; k < WIDTH; k++) begin
          if ((k / SLICE) == int'(cnt_q)) begin
            a_rec_d[k] = sum_q[k] ^ b_q[k] ^ c_q[k];
            sum_d[k]   = 1'b0;
            c_d[k+1]   = 1'b0;
          end
        end
        if (cnt_q == '0) begin
          state_d     = DONE;
          bck_valid_d = 1'b1;
          err_rev_d   = (a_rec_d != a_q);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end

      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
        a_d     = '0;
        b_d     = '0;
        sum_d   = '0;
        c_d     = '0;
        a_rec_d = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, datapath and strobe registers; reset discards any transaction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      c_q         <= '0;
      a_rec_q     <= '0;
      out_valid_q <= 1'b0;
      bck_valid_q <= 1'b0;
      err_dr_q    <= 1'b0;
      err_rev_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      c_q         <= c_d;
      a_rec_q     <= a_rec_d;
      out_valid_q <= out_valid_d;
      bck_valid_q <= bck_valid_d;
      err_dr_q    <= err_dr_d;
      err_rev_q   <= err_rev_d;
    end
  end

  // Outputs come only from registers; dual-rail outputs are null unless valid.
  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.s         = out_valid_q ? sum_q : '0;
  assign bus.s_n       = out_valid_q ? ~sum_q : '0;
  assign bus.cout      = out_valid_q & c_q[WIDTH];
  assign bus.cout_n    = out_valid_q & ~c_q[WIDTH];
  assign bus.bck_valid = bck_valid_q;
  assign bus.a_b       = bck_valid_q ? a_rec_q : '0;
  assign bus.a_b_n     = bck_valid_q ? ~a_rec_q : '0;
  assign bus.err_dr    = err_dr_q;
  assign bus.err_rev   = err_rev_q;

endmodule

// File: tb/tb_rev_addn_seq.sv
// Bench for rev_addn_seq: directed vector table at WIDTH=16/SLICE=4, hand
// sequences for hold, rail errors, mid-flight reset and carry corruption,
// plus random back-to-back traffic at 8/8 and 32/4.
module tb_rev_addn_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;
  int   cyc = 0;
  logic [16:0] cv_x;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  rev_addn_seq_if #(.WIDTH(16)) bus16 ();
  rev_addn_seq_if #(.WIDTH(8))  bus8 ();
  rev_addn_seq_if #(.WIDTH(32)) bus32 ();

  rev_addn_seq #(.WIDTH(16), .SLICE(4)) dut16 (.clk(clk), .rst_n(rst_n), .bus(bus16.slave));
  rev_addn_seq #(.WIDTH(8),  .SLICE(8)) dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8.slave));
  rev_addn_seq #(.WIDTH(32), .SLICE(4)) dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32.slave));

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        cin;
    logic [15:0] s;
    logic        cout;
  } vec_t;

  vec_t vt[6];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic drive16(input logic [15:0] a, input logic [15:0] b, input logic c);
    bus16.a = a;  bus16.a_n = ~a;
    bus16.b = b;  bus16.b_n = ~b;
    bus16.cin = c; bus16.cin_n = ~c;
  endtask

  task automatic null16();
    bus16.a = '0; bus16.a_n = '0; bus16.b = '0; bus16.b_n = '0;
    bus16.cin = 1'b0; bus16.cin_n = 1'b0;
  endtask

  task automatic chk_null(input string tag);
    chk({tag, "_in_ready"}, bus16.in_ready, 1);
    chk({tag, "_out_valid"}, bus16.out_valid, 0);
    chk({tag, "_s"}, {bus16.s, bus16.s_n}, 0);
    chk({tag, "_cout"}, {bus16.cout, bus16.cout_n}, 0);
    chk({tag, "_a_b"}, {bus16.a_b, bus16.a_b_n}, 0);
    chk({tag, "_strobes"}, {bus16.bck_valid, bus16.err_dr, bus16.err_rev}, 0);
  endtask

  // Present one operand set, return edges from acceptance to out_valid.
  task automatic fwd16(input logic [15:0] a, input logic [15:0] b, input logic c,
                       output int lat);
    int w;
    w = 0;
    while (!bus16.in_ready && w < 50) begin @(posedge clk); #1; w++; end
    drive16(a, b, c);
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    null16();
    lat = 0;
    while (!bus16.out_valid && lat < 50) begin @(posedge clk); #1; lat++; end
  endtask

  // Handshake the held result, then check the backward port.
  task automatic bwd16(input logic [15:0] exp_a, input logic exp_err);
    int n;
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    chk("ov_drop", bus16.out_valid, 0);
    chk("s_null_after_h", {bus16.s, bus16.s_n}, 0);
    n = 0;
    while (!bus16.bck_valid && n < 50) begin @(posedge clk); #1; n++; end
    chk("bck_lat", n, 4);
    chk("a_b", bus16.a_b, exp_a);
    chk("a_b_n", bus16.a_b_n, 16'(~exp_a));
    chk("err_rev", bus16.err_rev, exp_err);
    @(posedge clk); #1;
    chk("bck_pulse", bus16.bck_valid, 0);
    chk("a_b_null", {bus16.a_b, bus16.a_b_n}, 0);
    chk("idle_ready", bus16.in_ready, 1);
  endtask

  task automatic rnd8(input int n);
    logic [7:0] ca, cb, na, nb;
    logic cc, nc;
    logic [8:0] ex;
    int w, lat, prev, acc;
    ca = 8'($urandom); cb = 8'($urandom); cc = 1'($urandom);
    bus8.a = ca; bus8.a_n = ~ca; bus8.b = cb; bus8.b_n = ~cb;
    bus8.cin = cc; bus8.cin_n = ~cc;
    bus8.in_valid = 1'b1; bus8.out_ready = 1'b1;
    prev = 0;
    for (int t = 0; t < n; t++) begin
      w = 0;
      while (!bus8.in_ready && w < 100) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      acc = cyc;
      ex = 9'(ca) + 9'(cb) + 9'(cc);
      na = 8'($urandom); nb = 8'($urandom); nc = 1'($urandom);
      bus8.a = na; bus8.a_n = ~na; bus8.b = nb; bus8.b_n = ~nb;
      bus8.cin = nc; bus8.cin_n = ~nc;
      lat = 0;
      while (!bus8.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("r8_lat", lat, 1);
      chk("r8_s", bus8.s, ex[7:0]);
      chk("r8_cout", {bus8.cout, bus8.cout_n}, {ex[8], !ex[8]});
      w = 0;
      while (!bus8.bck_valid && w < 100) begin @(posedge clk); #1; w++; end
      chk("r8_bck_lat", w, 2);
      chk("r8_a_b", bus8.a_b, ca);
      chk("r8_err_rev", bus8.err_rev, 0);
      if (t > 0) chk("r8_period", acc - prev, 5);
      prev = acc;
      ca = na; cb = nb; cc = nc;
    end
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
  endtask

  task automatic rnd32(input int n);
    logic [31:0] ca, cb, na, nb;
    logic cc, nc;
    logic [32:0] ex;
    int w, lat, prev, acc;
    ca = $urandom; cb = $urandom; cc = 1'($urandom);
    bus32.a = ca; bus32.a_n = ~ca; bus32.b = cb; bus32.b_n = ~cb;
    bus32.cin = cc; bus32.cin_n = ~cc;
    bus32.in_valid = 1'b1; bus32.out_ready = 1'b1;
    prev = 0;
    for (int t = 0; t < n; t++) begin
      w = 0;
      while (!bus32.in_ready && w < 100) begin @(posedge clk); #1; w++; end
      @(posedge clk); #1;
      acc = cyc;
      ex = 33'(ca) + 33'(cb) + 33'(cc);
      na = $urandom; nb = $urandom; nc = 1'($urandom);
      bus32.a = na; bus32.a_n = ~na; bus32.b = nb; bus32.b_n = ~nb;
      bus32.cin = nc; bus32.cin_n = ~nc;
      lat = 0;
      while (!bus32.out_valid && lat < 100) begin @(posedge clk); #1; lat++; end
      chk("r32_lat", lat, 8);
      chk("r32_s", bus32.s, ex[31:0]);
      chk("r32_cout", {bus32.cout, bus32.cout_n}, {ex[32], !ex[32]});
      w = 0;
      while (!bus32.bck_valid && w < 100) begin @(posedge clk); #1; w++; end
      chk("r32_bck_lat", w, 9);
      chk("r32_a_b", bus32.a_b, ca);
      chk("r32_err_rev", bus32.err_rev, 0);
      if (t > 0) chk("r32_period", acc - prev, 19);
      prev = acc;
      ca = na; cb = nb; cc = nc;
    end
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;

    vt[0] = '{16'h1234, 16'h0FFF, 1'b0, 16'h2233, 1'b0};
    vt[1] = '{16'hFFFF, 16'h0001, 1'b1, 16'h0001, 1'b1};
    vt[2] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1};
    vt[3] = '{16'hAAAA, 16'h5555, 1'b1, 16'h0000, 1'b1};
    vt[4] = '{16'h0000, 16'h0000, 1'b0, 16'h0000, 1'b0};
    vt[5] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0};

    bus16.in_valid = 1'b0; bus16.out_ready = 1'b0; null16();
    bus8.in_valid = 1'b0; bus8.out_ready = 1'b0;
    bus8.a = '0; bus8.a_n = '0; bus8.b = '0; bus8.b_n = '0; bus8.cin = 1'b0; bus8.cin_n = 1'b0;
    bus32.in_valid = 1'b0; bus32.out_ready = 1'b0;
    bus32.a = '0; bus32.a_n = '0; bus32.b = '0; bus32.b_n = '0; bus32.cin = 1'b0; bus32.cin_n = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    chk_null("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk_null("post_reset");

    // Directed vector table.
    for (int i = 0; i < 6; i++) begin
      fwd16(vt[i].a, vt[i].b, vt[i].cin, lat);
      chk("vec_lat", lat, 4);
      chk("vec_s", bus16.s, vt[i].s);
      chk("vec_s_n", bus16.s_n, 16'(~vt[i].s));
      chk("vec_cout", {bus16.cout, bus16.cout_n}, {vt[i].cout, !vt[i].cout});
      chk("vec_hold_ready", bus16.in_ready, 0);
      bwd16(vt[i].a, 1'b0);
    end

    // Long hold with a competing in_valid.
    fwd16(16'h00FF, 16'h0101, 1'b0, lat);
    chk("hold_lat", lat, 4);
    drive16(16'hAAAA, 16'h1111, 1'b1);
    bus16.in_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("hold_s", bus16.s, 16'h0200);
      chk("hold_cout", {bus16.cout, bus16.cout_n}, 2'b01);
      chk("hold_ready", bus16.in_ready, 0);
      chk("hold_ov", bus16.out_valid, 1);
    end
    bus16.in_valid = 1'b0;
    null16();
    bwd16(16'h00FF, 1'b0);
    repeat (6) @(posedge clk);
    #1;
    chk("no_ghost_txn", bus16.out_valid, 0);

    // Illegal pair on a[3].
    drive16(16'h1234, 16'h0FFF, 1'b0);
    bus16.a[3] = 1'b1;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    null16();
    chk("err_dr_ill", bus16.err_dr, 1);
    chk("err_dr_ill_ready", bus16.in_ready, 1);
    chk("err_dr_ill_s", {bus16.s, bus16.s_n, bus16.out_valid}, 0);
    @(posedge clk); #1;
    chk("err_dr_ill_pulse", bus16.err_dr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_dr_ill_nofwd", {bus16.out_valid, bus16.in_ready}, 2'b01);

    // Null carry-in.
    drive16(16'h0001, 16'h0002, 1'b0);
    bus16.cin_n = 1'b0;
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    null16();
    chk("err_dr_null", bus16.err_dr, 1);
    chk("err_dr_null_ready", bus16.in_ready, 1);
    @(posedge clk); #1;
    chk("err_dr_null_pulse", bus16.err_dr, 0);
    repeat (5) @(posedge clk);
    #1;
    chk("err_dr_null_nofwd", {bus16.out_valid, bus16.s, bus16.s_n}, 0);

    // Reset after E2 of FWD.
    drive16(16'h1234, 16'h0FFF, 1'b0);
    bus16.in_valid = 1'b1;
    @(posedge clk); #1;
    bus16.in_valid = 1'b0;
    null16();
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_null("rst_fwd");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_null("rst_fwd_after");
    fwd16(vt[0].a, vt[0].b, vt[0].cin, lat);
    chk("rst_fwd_next_lat", lat, 4);
    chk("rst_fwd_next_s", bus16.s, vt[0].s);
    bwd16(vt[0].a, 1'b0);

    // Reset mid-BWD.
    fwd16(16'hFFFF, 16'h0001, 1'b1, lat);
    bus16.out_ready = 1'b1;
    @(posedge clk); #1;
    bus16.out_ready = 1'b0;
    @(posedge clk);
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk_null("rst_bwd");
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk_null("rst_bwd_after");
    fwd16(vt[1].a, vt[1].b, vt[1].cin, lat);
    chk("rst_bwd_next_lat", lat, 4);
    chk("rst_bwd_next_s", {bus16.s, bus16.cout}, {vt[1].s, vt[1].cout});
    bwd16(vt[1].a, 1'b0);

    // Corrupt carry bit 5 while holding the result.
    fwd16(16'h1234, 16'h0FFF, 1'b0, lat);
    cv_x = dut16.c_q ^ 17'h00020;
    force dut16.c_q = cv_x;
    @(posedge clk); #1;
    release dut16.c_q;
    chk("corrupt_s", bus16.s, 16'h2233);
    bwd16(16'h1234 ^ 16'h0020, 1'b1);

    // Random back-to-back traffic on the other two geometries.
    rnd8(20);
    rnd32(12);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
